// File: rtl/sort_job_ctrl.sv
// sort_job_ctrl: job sequencer that loads 32 features into the insert sorter,
// captures the sorter's output burst in a FIFO and replays it under valid/ready.
// Ports:
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_start, i_abort                        job control
//   i_feat_valid/o_feat_ready/i_feat_*      feature source handshake
//   o_sort_rst_n, o_sort_in_valid, o_sort_* sorter load side
//   i_sort_busy_rst, i_sort_out_valid, ...  sorter output burst
//   o_res_valid/i_res_ready/o_res_*         result sink handshake
//   o_busy, o_done, o_err                   status
module sort_job_ctrl #(
  parameter int N_IMG   = 32,
  parameter int IDX_W   = 5,
  parameter int TOT_W   = 23,
  parameter int COL_W   = 2,
  parameter int CLR_CYC = 2,
  parameter int OUT_TMO = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_feat_valid,
  output logic             o_feat_ready,
  input  logic [COL_W-1:0] i_feat_color,
  input  logic [TOT_W-1:0] i_feat_total,
  output logic             o_sort_rst_n,
  output logic             o_sort_in_valid,
  output logic [COL_W-1:0] o_sort_color,
  output logic [TOT_W-1:0] o_sort_total,
  output logic [IDX_W-1:0] o_sort_index,
  input  logic             i_sort_busy_rst,
  input  logic             i_sort_out_valid,
  input  logic [COL_W-1:0] i_sort_col_idx,
  input  logic [IDX_W-1:0] i_sort_img_idx,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [COL_W-1:0] o_res_color,
  output logic [IDX_W-1:0] o_res_index,
  output logic             o_res_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  localparam int AW  = $clog2(N_IMG);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(OUT_TMO);
  localparam int CCW = $clog2(CLR_CYC + 1);
  localparam logic [CW-1:0]  L_N    = CW'(N_IMG);
  localparam logic [CW-1:0]  L_N1   = CW'(N_IMG - 1);
  localparam logic [TW-1:0]  L_TMO2 = TW'(OUT_TMO - 2);
  localparam logic [CCW-1:0] L_CLR1 = CCW'(CLR_CYC - 1);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_WAIT, S_DRAIN, S_EMIT} state_t;
  state_t                   r_state;
  logic [CW-1:0]            r_load_cnt, r_cap_cnt, r_rd_cnt;
  logic [TW-1:0]            r_tmo;
  logic [CCW-1:0]           r_clr_cnt;
  logic                     r_armed, r_sort_rst_n, r_sort_in_valid, r_done, r_err;
  logic [COL_W-1:0]         r_sort_color;
  logic [TOT_W-1:0]         r_sort_total;
  logic [IDX_W-1:0]         r_sort_index;
  logic [COL_W+IDX_W-1:0]   r_mem [N_IMG];
  logic                     w_res_valid, w_pop, w_acc, w_wr;
  logic [COL_W+IDX_W-1:0]   w_rd_data;
  // The FIFO never wraps within a job, so the capture and read counters double
  // as its write/read pointers and their difference is its fill level.
  assign w_res_valid = (r_state == S_DRAIN || r_state == S_EMIT) && (r_cap_cnt != r_rd_cnt);
  assign w_pop       = w_res_valid && i_res_ready;
  assign w_acc       = o_feat_ready && i_feat_valid;
  assign w_wr        = i_sort_out_valid && (r_state == S_WAIT || r_state == S_DRAIN);
  assign w_rd_data   = r_mem[r_rd_cnt[AW-1:0]];
  assign o_feat_ready    = (r_state == S_LOAD) && (r_load_cnt < L_N);
  assign o_sort_rst_n    = r_sort_rst_n;
  assign o_sort_in_valid = r_sort_in_valid;
  assign o_sort_color    = r_sort_color;
  assign o_sort_total    = r_sort_total;
  assign o_sort_index    = r_sort_index;
  assign o_res_valid     = w_res_valid;
  assign o_res_color     = w_res_valid ? w_rd_data[COL_W+IDX_W-1:IDX_W] : '0;
  assign o_res_index     = w_res_valid ? w_rd_data[IDX_W-1:0] : '0;
  assign o_res_last      = w_res_valid && (r_rd_cnt == L_N1);
  assign o_busy          = r_state != S_IDLE;
  assign o_done          = r_done;
  assign o_err           = r_err;
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_cap_cnt[AW-1:0]] <= {i_sort_col_idx, i_sort_img_idx};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_load_cnt      <= '0;
      r_cap_cnt       <= '0;
      r_rd_cnt        <= '0;
      r_tmo           <= '0;
      r_clr_cnt       <= '0;
      r_armed         <= 1'b0;
      r_sort_rst_n    <= 1'b0;
      r_sort_in_valid <= 1'b0;
      r_sort_color    <= '0;
      r_sort_total    <= '0;
      r_sort_index    <= '0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_sort_in_valid <= 1'b0;
      // sorter reset stays low until the first job arms it, then each pulse lasts CLR_CYC cycles
      if (r_clr_cnt != '0) r_clr_cnt <= r_clr_cnt - 1'b1;
      else if (r_armed) r_sort_rst_n <= 1'b1;
      if (w_wr) r_cap_cnt <= r_cap_cnt + 1'b1;
      if (w_pop) r_rd_cnt <= r_rd_cnt + 1'b1;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state      <= S_CLR;
          r_armed      <= 1'b1;
          r_sort_rst_n <= 1'b0;
          r_clr_cnt    <= L_CLR1;
          r_load_cnt   <= '0;
          r_cap_cnt    <= '0;
          r_rd_cnt     <= '0;
        end
        S_CLR: if (r_sort_rst_n && i_sort_busy_rst) r_state <= S_LOAD;
        S_LOAD: begin
          r_tmo <= '0;
          if (w_acc) begin
            r_sort_in_valid <= 1'b1;
            r_sort_index    <= r_load_cnt[IDX_W-1:0];
            r_sort_color    <= i_feat_color;
            r_sort_total    <= i_feat_total;
            r_load_cnt      <= r_load_cnt + 1'b1;
          end
          if (r_load_cnt == L_N) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // WAIT starts one cycle after the last load, so err lands OUT_TMO cycles after it
          if (i_sort_out_valid) r_state <= S_DRAIN;
          else if (r_tmo == L_TMO2) begin
            r_state      <= S_IDLE;
            r_err        <= 1'b1;
            r_cap_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_sort_rst_n <= 1'b0;
            r_clr_cnt    <= L_CLR1;
          end else r_tmo <= r_tmo + 1'b1;
        end
        S_DRAIN: if (w_wr && r_cap_cnt == L_N1) r_state <= S_EMIT;
        S_EMIT: if (r_rd_cnt == L_N) begin
          r_state      <= S_IDLE;
          r_done       <= 1'b1;
          r_sort_rst_n <= 1'b0;
          r_clr_cnt    <= L_CLR1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (i_abort && r_state != S_IDLE) begin
        r_state         <= S_IDLE;
        r_cap_cnt       <= '0;
        r_rd_cnt        <= '0;
        r_sort_in_valid <= 1'b0;
        r_sort_rst_n    <= 1'b0;
        r_clr_cnt       <= L_CLR1;
        r_done          <= 1'b0;
        r_err           <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sort_job_ctrl.sv
// tb_sort_job_ctrl: randomized job-level bench with a behavioural sorter model and scoreboard.
module tb_sort_job_ctrl;
  localparam int N = 32;
  localparam int TMO = 64;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, feat_valid = 0, feat_ready;
  logic [1:0] feat_color = 0;
  logic [22:0] feat_total = 0;
  logic sort_rst_n, sort_in_valid;
  logic [1:0] sort_color;
  logic [22:0] sort_total;
  logic [4:0] sort_index;
  logic busy_rst = 0, out_valid = 0;
  logic [1:0] out_col = 0;
  logic [4:0] out_img = 0;
  logic res_valid, res_ready = 1, res_last, busy, done, err;
  logic [1:0] res_color;
  logic [4:0] res_index;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  sort_job_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_feat_valid(feat_valid), .o_feat_ready(feat_ready),
    .i_feat_color(feat_color), .i_feat_total(feat_total),
    .o_sort_rst_n(sort_rst_n), .o_sort_in_valid(sort_in_valid),
    .o_sort_color(sort_color), .o_sort_total(sort_total), .o_sort_index(sort_index),
    .i_sort_busy_rst(busy_rst), .i_sort_out_valid(out_valid),
    .i_sort_col_idx(out_col), .i_sort_img_idx(out_img),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_color(res_color), .o_res_index(res_index), .o_res_last(res_last),
    .o_busy(busy), .o_done(done), .o_err(err)
  );
  // sorter model: collects loads, then after a latency emits them in ascending total order
  bit sorter_on = 1;
  int lat = 4, phase = 0, wcnt = 0, epos = 0;
  logic [29:0] ldq[$];
  logic [6:0] emitq[$];
  logic [29:0] srt[N];
  logic [29:0] tmp;
  initial forever begin
    @(posedge clk); #1;
    busy_rst = sort_rst_n;
    out_valid = 0;
    if (!sort_rst_n) begin
      ldq.delete();
      phase = 0;
    end else begin
      if (sort_in_valid) ldq.push_back({sort_color, sort_index, sort_total});
      if (phase == 0 && ldq.size() == N && sorter_on) begin
        phase = 1;
        wcnt = lat;
      end else if (phase == 1) begin
        if (wcnt == 0) begin
          for (int i = 0; i < N; i++) srt[i] = ldq[i];
          for (int i = 0; i < N - 1; i++)
            for (int j = i + 1; j < N; j++)
              if (srt[j][22:0] < srt[i][22:0]) begin
                tmp = srt[i]; srt[i] = srt[j]; srt[j] = tmp;
              end
          epos = 0;
          phase = 2;
        end else wcnt--;
      end
      if (phase == 2) begin
        out_valid = 1;
        out_col = srt[epos][29:28];
        out_img = srt[epos][27:23];
        emitq.push_back({out_col, out_img});
        epos++;
        if (epos == N) phase = 3;
      end
    end
  end
  // monitor: records strobes, accepted results, pulses and stall stability
  int cyc = 0, last_ld_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0, viol = 0;
  logic [29:0] stq[$];
  logic [7:0] rsq[$];
  bit prev_stall = 0;
  logic [7:0] prev_res = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (sort_in_valid) begin
      stq.push_back({sort_color, sort_index, sort_total});
      last_ld_cyc = cyc;
    end
    if (res_valid && res_ready) rsq.push_back({res_color, res_index, res_last});
    if (prev_stall && !(res_valid && {res_color, res_index, res_last} == prev_res)) viol++;
    prev_stall = res_valid && !res_ready;
    prev_res = {res_color, res_index, res_last};
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end
  logic [1:0] f_col[N];
  logic [22:0] f_tot[N];
  task automatic clear_obs();
    stq.delete(); rsq.delete(); emitq.delete();
    done_cnt = 0; err_cnt = 0; viol = 0; prev_stall = 0;
  endtask
  task automatic gen_words();
    for (int i = 0; i < N; i++) begin
      f_col[i] = 2'($urandom_range(3));
      f_tot[i] = 23'($urandom);
    end
    lat = $urandom_range(8);
  endtask
  task automatic run_job(input bit toggle, input int nload);
    int sent = 0, guard = 0;
    bit tog = 1;
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    while (sent < nload && guard < 3000) begin
      feat_valid = !toggle || tog;
      tog = !tog;
      feat_color = f_col[sent];
      feat_total = f_tot[sent];
      @(negedge clk);
      if (feat_valid && feat_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    feat_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({sort_rst_n, sort_in_valid, feat_ready, res_valid, res_last, busy, done, err, res_color, res_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0", {sort_rst_n, sort_in_valid, feat_ready, res_valid, res_last, busy, done, err, res_color, res_index});
    end
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (sort_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL sorter_held_until_start got %b want 0", sort_rst_n);
    end
  endtask
  task automatic test_basic();
    int x, bad = 0, k;
    x = $urandom_range(31);
    for (int i = 0; i < N; i++) begin
      f_col[i] = 2'($urandom_range(3));
      f_tot[i] = 23'(100 + (i ^ x));
    end
    lat = $urandom_range(8);
    clear_obs();
    res_ready = 1;
    run_job(0, N);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_during_job got %b want 1", busy);
    end
    wait_idle();
    n_tests++;
    if (stq.size() != N) begin
      n_fail++;
      $display("FAIL basic_strobes got %0d want %0d", stq.size(), N);
    end
    for (int i = 0; i < stq.size(); i++) if (stq[i] !== {f_col[i], 5'(i), f_tot[i]}) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL basic_strobe_data got %0d bad want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < rsq.size(); i++) begin
      k = i ^ x;
      if (rsq[i] !== {f_col[k], 5'(k), i == N - 1}) bad++;
    end
    n_tests++;
    if (rsq.size() != N || bad != 0) begin
      n_fail++;
      $display("FAIL basic_results got %0d entries %0d bad want %0d entries 0 bad", rsq.size(), bad, N);
    end
    n_tests++;
    if (done_cnt != 1 || err_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done got done=%0d err=%0d busy=%b want 1 0 0", done_cnt, err_cnt, busy);
    end
  endtask
  task automatic test_gaps();
    int bad = 0;
    gen_words();
    clear_obs();
    run_job(1, N);
    wait_idle();
    for (int i = 0; i < stq.size(); i++) if (stq[i] !== {f_col[i], 5'(i), f_tot[i]}) bad++;
    n_tests++;
    if (stq.size() != N || bad != 0) begin
      n_fail++;
      $display("FAIL gaps_loads got %0d loads %0d bad want %0d loads 0 bad", stq.size(), bad, N);
    end
    bad = 0;
    for (int i = 0; i < rsq.size() && i < emitq.size(); i++) if (rsq[i] !== {emitq[i], i == N - 1}) bad++;
    n_tests++;
    if (rsq.size() != N || emitq.size() != N || bad != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL gaps_results got %0d entries %0d bad done=%0d want %0d 0 1", rsq.size(), bad, done_cnt, N);
    end
  endtask
  task automatic test_stall();
    int bad = 0;
    bit seen = 0;
    gen_words();
    clear_obs();
    res_ready = 1;
    fork
      run_job(0, N);
      begin
        for (int i = 0; i < 1000 && !seen; i++) begin
          @(posedge clk); #1;
          seen = res_valid;
        end
        res_ready = 0;
        repeat (40) @(posedge clk);
        #1;
        res_ready = 1;
      end
    join
    wait_idle();
    n_tests++;
    if (!seen || viol != 0) begin
      n_fail++;
      $display("FAIL stall_stable got seen=%0d changes=%0d want 1 0", seen, viol);
    end
    for (int i = 0; i < rsq.size() && i < emitq.size(); i++) if (rsq[i] !== {emitq[i], i == N - 1}) bad++;
    n_tests++;
    if (rsq.size() != N || emitq.size() != N || bad != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL stall_results got %0d entries %0d bad done=%0d want %0d 0 1", rsq.size(), bad, done_cnt, N);
    end
  endtask
  task automatic test_timeout();
    gen_words();
    clear_obs();
    sorter_on = 0;
    run_job(0, N);
    wait_idle();
    sorter_on = 1;
    n_tests++;
    if (err_cnt != 1 || done_cnt != 0 || busy !== 1'b0 || rsq.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_pulse got err=%0d done=%0d busy=%b res=%0d want 1 0 0 0", err_cnt, done_cnt, busy, rsq.size());
    end
    n_tests++;
    if (err_cyc - last_ld_cyc != TMO) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d want %0d", err_cyc - last_ld_cyc, TMO);
    end
  endtask
  task automatic test_abort();
    int bad = 0;
    gen_words();
    clear_obs();
    run_job(0, 17);
    repeat (2) @(posedge clk);
    #1;
    abort = 1;
    start = 1;
    @(posedge clk); #1;
    abort = 0;
    start = 0;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || sort_rst_n !== 1'b0 || stq.size() != 17) begin
      n_fail++;
      $display("FAIL abort_state got busy=%b resv=%b srst=%b loads=%0d want 0 0 0 17", busy, res_valid, sort_rst_n, stq.size());
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (sort_rst_n !== 1'b1 || done_cnt != 0 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_release got srst=%b done=%0d err=%0d want 1 0 0", sort_rst_n, done_cnt, err_cnt);
    end
    gen_words();
    clear_obs();
    run_job(0, N);
    wait_idle();
    for (int i = 0; i < stq.size(); i++) if (stq[i] !== {f_col[i], 5'(i), f_tot[i]}) bad++;
    for (int i = 0; i < rsq.size() && i < emitq.size(); i++) if (rsq[i] !== {emitq[i], i == N - 1}) bad++;
    n_tests++;
    if (stq.size() != N || rsq.size() != N || emitq.size() != N || bad != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL abort_rerun got loads=%0d res=%0d bad=%0d done=%0d want %0d %0d 0 1", stq.size(), rsq.size(), bad, done_cnt, N, N);
    end
  endtask
  task automatic test_rst_emit();
    int bad = 0;
    gen_words();
    clear_obs();
    res_ready = 0;
    run_job(0, N);
    for (int i = 0; i < 500 && phase != 3; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL emit_reached got busy=%b resv=%b want 1 1", busy, res_valid);
    end
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    n_tests++;
    if ({sort_rst_n, sort_in_valid, feat_ready, res_valid, res_last, busy, done, err, res_color, res_index} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs got %b want 0", {sort_rst_n, sort_in_valid, feat_ready, res_valid, res_last, busy, done, err, res_color, res_index});
    end
    @(posedge clk); #1;
    rst_n = 1;
    res_ready = 1;
    @(posedge clk); #1;
    gen_words();
    clear_obs();
    run_job(0, N);
    wait_idle();
    for (int i = 0; i < rsq.size() && i < emitq.size(); i++) if (rsq[i] !== {emitq[i], i == N - 1}) bad++;
    n_tests++;
    if (stq.size() != N || rsq.size() != N || emitq.size() != N || bad != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL reset_rerun got loads=%0d res=%0d bad=%0d done=%0d want %0d %0d 0 1", stq.size(), rsq.size(), bad, done_cnt, N, N);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_timeout();
    test_abort();
    test_rst_emit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
